// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous 8-bit SRAM: round-robin grant,
// fixed SETUP / STROBE / RECOVER timing, every output straight from a flop.
module sram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int ACCESS_CYCLES = 2,
  parameter int RECOVERY      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;  // 1 = host
  logic                grant_q, grant_d;            // 1 = host
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d;
  logic [7:0]          host_rdata_q, host_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                busy_q, busy_d;
  logic                pick_host;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    pick_host    = host_req && (!cpu_req || !last_grant_q);

    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          state_d      = SETUP;
          grant_d      = pick_host;
          last_grant_d = pick_host;
          addr_d       = pick_host ? host_addr  : cpu_addr;
          we_d         = pick_host ? host_we    : cpu_we;
          wdata_d      = pick_host ? host_wdata : cpu_wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(ACCESS_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = RECOVER;
          cnt_d   = 4'(RECOVERY - 1);
          if (!we_q) begin
            if (grant_q) host_rdata_d = sram_dq_in;
            else         cpu_rdata_d  = sram_dq_in;
          end
          // Registered here so the pulse lands on the first RECOVER cycle.
          cpu_ack_d  = !grant_q;
          host_ack_d = grant_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they change with it.
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = !((state_d == STROBE) && !we_d);
    we_n_d  = !((state_d == STROBE) && we_d);
    dq_oe_d = (state_d != IDLE) && we_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dq_oe_q      <= dq_oe_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign host_ack    = host_ack_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-timing instance plus a fast
// (ACCESS_CYCLES=1) instance for back-to-back reads.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [18:0] cpu_addr, host_addr;
  logic [7:0]  cpu_wdata, host_wdata, sram_dq_in;
  logic [7:0]  cpu_rdata, host_rdata, sram_dq_out;
  logic        cpu_ack, host_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;
  logic [18:0] sram_addr;

  logic        b_cpu_req, b_host_req;
  logic [7:0]  b_sram_dq_in, b_cpu_rdata, b_host_rdata, b_sram_dq_out;
  logic        b_cpu_ack, b_host_ack, b_sram_dq_oe, b_sram_ce_n, b_sram_oe_n, b_sram_we_n, b_busy;
  logic [18:0] b_sram_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(19), .ACCESS_CYCLES(1), .RECOVERY(1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(19'h00042), .cpu_wdata(8'h00),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .host_req(b_host_req), .host_we(1'b0), .host_addr(19'h00000), .host_wdata(8'h00),
    .host_rdata(b_host_rdata), .host_ack(b_host_ack),
    .sram_addr(b_sram_addr), .sram_dq_out(b_sram_dq_out), .sram_dq_oe(b_sram_dq_oe),
    .sram_dq_in(b_sram_dq_in), .sram_ce_n(b_sram_ce_n), .sram_oe_n(b_sram_oe_n),
    .sram_we_n(b_sram_we_n), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Bus-level invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl_oe_we", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      chk("dq_oe_while_oe", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
      chk("ack_overlap", 32'(cpu_ack && host_ack), 32'd0);
      chk("fast_excl_oe_we", 32'(!b_sram_oe_n && !b_sram_we_n), 32'd0);
      chk("fast_ack_overlap", 32'(b_cpu_ack && b_host_ack), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access from one side; counts strobe cycles relative to the sampling edge.
  task automatic do_access(input bit host, input bit we, input logic [18:0] addr,
                           input logic [7:0] wd, input bit move_addr,
                           output int ack_cyc, output int ce_cnt, output int oe_cnt,
                           output int we_cnt, output int dqoe_cnt, output int acks,
                           output int addr_bad, output int dq_bad);
    bit done = 0;
    bit dropreq = 0;
    ack_cyc = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    acks = 0; addr_bad = 0; dq_bad = 0;
    if (host) begin host_req = 1; host_we = we; host_addr = addr; host_wdata = wd; end
    else      begin cpu_req  = 1; cpu_we  = we; cpu_addr  = addr; cpu_wdata  = wd; end
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      if (dropreq) begin
        if (host) host_req = 0; else cpu_req = 0;
        dropreq = 0;
      end
      if (move_addr && k == 2) begin
        if (host) begin host_addr = '0; host_wdata = 8'hFF; end
        else      begin cpu_addr  = '0; cpu_wdata  = 8'hFF; end
      end
      @(negedge clk);
      if (!sram_ce_n) ce_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) dqoe_cnt++;
      if (busy && sram_addr !== addr) addr_bad++;
      if (sram_dq_oe && sram_dq_out !== wd) dq_bad++;
      if (host ? host_ack : cpu_ack) begin
        acks++;
        if (ack_cyc == 0) ack_cyc = k;
        dropreq = 1;
      end
      if (ack_cyc != 0 && !busy) done = 1;
    end
    if (host) host_req = 0; else cpu_req = 0;
  endtask

  int ack_cyc, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, acks, addr_bad, dq_bad;
  int n;
  int who [4];
  int when [4];

  initial begin
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    sram_dq_in = '0; b_cpu_req = 0; b_host_req = 0; b_sram_dq_in = 8'h99;

    // Reset state, sampled while reset is held
    repeat (2) @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_acks", {cpu_ack, host_ack}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", {cpu_rdata, host_rdata}, 16'h0000);
    chk("rst_addr", sram_addr, 0);
    do_reset();

    // CPU read 0x12345, SRAM returns 0xA5
    sram_dq_in = 8'hA5;
    do_access(0, 0, 19'h12345, 8'h00, 0, ack_cyc, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, acks, addr_bad, dq_bad);
    chk("rd_ack_cycle", ack_cyc, 4);
    chk("rd_ce_cycles", ce_cnt, 4);
    chk("rd_oe_cycles", oe_cnt, 2);
    chk("rd_we_cycles", we_cnt, 0);
    chk("rd_dqoe_cycles", dqoe_cnt, 0);
    chk("rd_ack_pulses", acks, 1);
    chk("rd_addr_bad", addr_bad, 0);
    chk("rd_cpu_rdata", cpu_rdata, 8'hA5);
    chk("rd_host_rdata", host_rdata, 8'h00);

    // Host write 0x3C to 0x00010
    sram_dq_in = 8'hEE;
    do_access(1, 1, 19'h00010, 8'h3C, 0, ack_cyc, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, acks, addr_bad, dq_bad);
    chk("wr_ack_cycle", ack_cyc, 4);
    chk("wr_dqoe_cycles", dqoe_cnt, 4);
    chk("wr_we_cycles", we_cnt, 2);
    chk("wr_oe_cycles", oe_cnt, 0);
    chk("wr_dq_bad", dq_bad, 0);
    chk("wr_ack_pulses", acks, 1);
    chk("wr_cpu_rdata", cpu_rdata, 8'hA5);
    chk("wr_host_rdata", host_rdata, 8'h00);

    // Address changes mid-access must not reach the SRAM
    sram_dq_in = 8'h5A;
    do_access(0, 0, 19'h7FFFF, 8'h00, 1, ack_cyc, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, acks, addr_bad, dq_bad);
    chk("hold_addr_bad", addr_bad, 0);
    chk("hold_ack_cycle", ack_cyc, 4);
    chk("hold_cpu_rdata", cpu_rdata, 8'h5A);

    // Contention straight after reset: CPU, host, CPU
    do_reset();
    sram_dq_in = 8'h11;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00100;
    host_req = 1; host_we = 0; host_addr = 19'h00200;
    n = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (cpu_ack && n < 4)  begin who[n] = 0; when[n] = k; n++; end
      if (host_ack && n < 4) begin who[n] = 1; when[n] = k; n++; end
    end
    cpu_req = 0; host_req = 0;
    chk("rr_ack_count", n, 3);
    chk("rr_first_cpu", who[0], 0);
    chk("rr_second_host", who[1], 1);
    chk("rr_third_cpu", who[2], 0);
    chk("rr_cycle0", when[0], 4);
    chk("rr_cycle1", when[1], 9);
    chk("rr_cycle2", when[2], 14);
    chk("rr_rdata", {cpu_rdata, host_rdata}, 16'h1111);
    repeat (4) @(negedge clk);

    // Reset mid-STROBE of a host write, then the held request reruns
    @(posedge clk); #1;
    host_req = 1; host_we = 1; host_addr = 19'h00055; host_wdata = 8'h77;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_strobe_we_n", sram_we_n, 0);
    chk("mid_strobe_dq_oe", sram_dq_oe, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_dq_oe", sram_dq_oe, 0);
    chk("abort_ce_n", sram_ce_n, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_no_ack", host_ack, 0);
    rst_n = 1;
    do_access(1, 1, 19'h00055, 8'h77, 0, ack_cyc, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, acks, addr_bad, dq_bad);
    chk("rerun_ack_cycle", ack_cyc, 4);
    chk("rerun_ack_pulses", acks, 1);
    chk("rerun_we_cycles", we_cnt, 2);

    // Fast instance: held CPU read request -> ack every 4 cycles
    @(posedge clk); #1;
    b_cpu_req = 1;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (b_cpu_ack && n < 4) begin when[n] = k; n++; end
    end
    b_cpu_req = 0;
    chk("fast_ack_count", n, 3);
    chk("fast_ack0", when[0], 3);
    chk("fast_ack1", when[1], 7);
    chk("fast_ack2", when[2], 11);
    chk("fast_rdata", b_cpu_rdata, 8'h99);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SRAM address width.
REQ-002 Parameter ACCESS_CYCLES, default 2, strobe-low cycles per access; legal range 1..15.
REQ-003 Parameter RECOVERY, default 1, strobe-high cycles after each access; legal range 1..7.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU-side request, level, held high until cpu_ack is sampled.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  CPU-side address.
REQ-009 cpu_wdata  in  8  CPU-side write data.
REQ-010 cpu_rdata  out  8  CPU-side read data, registered.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 host_req, host_we, host_addr, host_wdata, host_rdata, host_ack: same directions, widths and meanings as the cpu_* ports, for the host-side requester.
REQ-013 sram_addr  out  ADDR_W  SRAM address.
REQ-014 sram_dq_out  out  8  data driven to SRAM.
REQ-015 sram_dq_oe  out  1  enable for the top-level tristate on the SRAM data bus.
REQ-016 sram_dq_in  in  8  data read from SRAM.
REQ-017 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, SETUP (1 cycle), STROBE (ACCESS_CYCLES cycles), RECOVER (RECOVERY cycles); RECOVER returns to IDLE.
REQ-020 Leave IDLE only when cpu_req or host_req is high; a grant is taken on the IDLE->SETUP edge.
REQ-021 Only one requester: grant it. Both requesting: grant the requester not granted last (round-robin via a last_grant bit).
REQ-022 On grant, capture addr, we and wdata of the granted side into internal registers; requester input changes after the grant do not affect the access in progress.
REQ-023 SETUP: sram_ce_n=0, sram_addr=captured address, oe_n=1, we_n=1; for writes, sram_dq_oe=1 and sram_dq_out=captured data.
REQ-024 STROBE, reads: sram_oe_n=0, sram_dq_oe=0.
REQ-025 STROBE, writes: sram_we_n=0, sram_dq_oe=1.
REQ-026 STROBE length is controlled by a 4-bit down-counter loaded with ACCESS_CYCLES-1.
REQ-027 Reads: on the final STROBE edge, capture sram_dq_in into the granted side's rdata; the other side's rdata is unchanged. Writes leave both rdata outputs unchanged.
REQ-028 RECOVER: strobes high, sram_ce_n=0, sram_addr held, sram_dq_oe held for writes (data hold time).
REQ-029 The granted side's ack is high for exactly the first RECOVER cycle; the two acks are never high together.
REQ-030 Latency: req sampled high in IDLE at edge N -> ack high in the cycle after edge N+1+ACCESS_CYCLES (4 cycles at defaults); first IDLE after RECOVERY cycles.
REQ-031 A requester drops req on the edge where it samples ack; req still high at the next IDLE sample is a new request (back-to-back is legal).
REQ-032 sram_we_n and sram_oe_n are never low together; sram_dq_oe is never high while sram_oe_n is low.
REQ-033 IDLE outputs: sram_ce_n=1, oe_n=1, we_n=1, sram_dq_oe=0, sram_addr holds its last value.
REQ-034 All outputs are driven from registers (no combinational paths from inputs to outputs).

Reset
REQ-035 rst_n low immediately forces: state IDLE, sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, cpu_ack=host_ack=0, busy=0, rdata=0x00, sram_addr=0, last_grant=host (the CPU wins the first contention).
REQ-036 Reset during SETUP, STROBE or RECOVER aborts the access without an ack; after release the FSM starts from IDLE and re-arbitrates any held requests.

Verification
REQ-037 Defaults; CPU read of addr 0x12345 with SRAM returning 0xA5 -> ce_n low for 4 cycles, oe_n low for 2 cycles, cpu_ack at cycle 4, cpu_rdata=0xA5, host_rdata unchanged.
REQ-038 Host write of 0x3C to 0x00010 -> dq_oe high for SETUP through RECOVER, we_n low for 2 cycles, sram_dq_out=0x3C, host_ack one pulse.
REQ-039 cpu_req and host_req rise on the same edge after reset and both are held -> CPU served first, then host, then CPU (alternating); no ack overlap, no idle gap beyond RECOVERY.
REQ-040 Change cpu_addr to 0x00000 during STROBE of a read at 0x7FFFF -> sram_addr stays 0x7FFFF until IDLE.
REQ-041 Assert rst_n low mid-STROBE of a write -> we_n=1 and dq_oe=0 with no clock edge, no ack; after release a held host_req completes normally.
REQ-042 ACCESS_CYCLES=1, RECOVERY=1, with back-to-back CPU reads -> ack every 4 cycles; oe_n and we_n never low together throughout.
